pwm_multi: RTL and testbench

- Parametrised successor to the single-channel PWM: CHANNELS independent outputs share one WIDTH-bit period counter.
- Adds a synchronous reset, enable, edge- or centre-aligned counting, and per-channel polarity.
- Period, duty and mode go through double-buffered shadow registers, which update only at a period boundary, so outputs never glitch mid-period.
- Sits between a control/register block and pad drivers (motor, LED, servo).

---
 rtl/pwm_multi.sv | 156 +++++++++++++++
 tb/tb_pwm_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter, edge/centre alignment,
// per-channel polarity and shadow registers that update on period boundaries.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       invert,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_end,
  output logic                      load_ack,
  output logic [WIDTH-1:0]          cnt
);

  logic [WIDTH-1:0]          r_cnt, w_cnt_n;
  logic                      r_dn, w_dn_n;
  logic                      r_run, r_ack, w_ack_n;
  logic [CHANNELS-1:0]       r_pwm, w_pwm_n;

  logic [WIDTH-1:0]          r_a_per, r_p_per, w_a_per_n, w_p_per_n;
  logic [CHANNELS*WIDTH-1:0] r_a_duty, r_p_duty, w_a_duty_n, w_p_duty_n;
  logic                      r_a_mode, r_p_mode, w_a_mode_n, w_p_mode_n;
  logic [CHANNELS-1:0]       r_a_inv, r_p_inv, w_a_inv_n, w_p_inv_n;
  logic                      r_pv, w_pv_n;

  logic                      w_pzero, w_bound, w_idle;
  logic                      w_take_in, w_take_p, w_to_p;
  logic [WIDTH-1:0]          w_pm1;

  assign w_pzero = (r_a_per == '0);
  assign w_pm1   = w_pzero ? '0 : r_a_per - WIDTH'(1);
  assign w_bound = r_run & ~w_pzero &
                   (r_a_mode ? (r_dn & (r_cnt == '0))
                             : (r_cnt == w_pm1));

  // With no running period (disabled or P==0) pending values apply at once.
  assign w_idle    = ~en | w_pzero;
  assign w_take_in = ~w_idle & w_bound & load;
  assign w_take_p  = r_pv & ~load & (w_idle | w_bound);
  assign w_to_p    = load & ~w_take_in;

  always_comb begin
    w_a_per_n  = r_a_per;
    w_a_duty_n = r_a_duty;
    w_a_mode_n = r_a_mode;
    w_a_inv_n  = r_a_inv;
    w_p_per_n  = r_p_per;
    w_p_duty_n = r_p_duty;
    w_p_mode_n = r_p_mode;
    w_p_inv_n  = r_p_inv;
    w_pv_n     = r_pv;
    w_ack_n    = 1'b0;
    unique case (1'b1)
      w_take_in: begin
        w_a_per_n  = period;
        w_a_duty_n = duty;
        w_a_mode_n = mode;
        w_a_inv_n  = invert;
        w_pv_n     = 1'b0;
        w_ack_n    = 1'b1;
      end
      w_take_p: begin
        w_a_per_n  = r_p_per;
        w_a_duty_n = r_p_duty;
        w_a_mode_n = r_p_mode;
        w_a_inv_n  = r_p_inv;
        w_pv_n     = 1'b0;
        w_ack_n    = 1'b1;
      end
      w_to_p: begin
        w_p_per_n  = period;
        w_p_duty_n = duty;
        w_p_mode_n = mode;
        w_p_inv_n  = invert;
        w_pv_n     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_cnt_n = '0;
    w_dn_n  = 1'b0;
    if (en && r_run && !w_pzero && !w_bound) begin
      if (!r_a_mode) begin
        w_cnt_n = r_cnt + WIDTH'(1);
      end else if (!r_dn) begin
        // Apex value is held for a second cycle as the down leg begins.
        if (r_cnt == w_pm1) begin
          w_cnt_n = r_cnt;
          w_dn_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + WIDTH'(1);
        end
      end else begin
        w_cnt_n = r_cnt - WIDTH'(1);
        w_dn_n  = 1'b1;
      end
    end
  end

  always_comb begin
    w_pwm_n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pwm_n[i] = w_a_inv_n[i] ^
                   (en && (w_a_per_n != '0) &&
                    (w_cnt_n < w_a_duty_n[i*WIDTH +: WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_dn     <= 1'b0;
      r_run    <= 1'b0;
      r_ack    <= 1'b0;
      r_pwm    <= '0;
      r_a_per  <= '0;
      r_a_duty <= '0;
      r_a_mode <= 1'b0;
      r_a_inv  <= '0;
      r_p_per  <= '0;
      r_p_duty <= '0;
      r_p_mode <= 1'b0;
      r_p_inv  <= '0;
      r_pv     <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_dn     <= w_dn_n;
      r_run    <= en;
      r_ack    <= w_ack_n;
      r_pwm    <= w_pwm_n;
      r_a_per  <= w_a_per_n;
      r_a_duty <= w_a_duty_n;
      r_a_mode <= w_a_mode_n;
      r_a_inv  <= w_a_inv_n;
      r_p_per  <= w_p_per_n;
      r_p_duty <= w_p_duty_n;
      r_p_mode <= w_p_mode_n;
      r_p_inv  <= w_p_inv_n;
      r_pv     <= w_pv_n;
    end
  end

  assign pwm_out    = r_pwm;
  assign period_end = w_bound;
  assign load_ack   = r_ack;
  assign cnt        = r_cnt;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: directed stimulus queues per-cycle
// expectations, a monitor pops and compares after each rising edge.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst_n, en, load, mode;
  logic [7:0]  period;
  logic [31:0] duty;
  logic [3:0]  invert;
  logic [3:0]  pwm_out;
  logic        period_end, load_ack;
  logic [7:0]  cnt;

  typedef struct {
    logic [3:0] pwm;
    logic       pe;
    logic       ack;
    logic [7:0] c;
    int         ph;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   total = 0;
  int   bad   = 0;
  int   ph    = 0;
  int   nidx  = 0;

  pwm_multi #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .load(load),
    .period(period),
    .duty(duty),
    .mode(mode),
    .invert(invert),
    .pwm_out(pwm_out),
    .period_end(period_end),
    .load_ack(load_ack),
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [3:0] p, input logic pe,
                      input logic ack, input int c);
    exp_t e;
    e.pwm = p;
    e.pe  = pe;
    e.ack = ack;
    e.c   = 8'(c);
    e.ph  = ph;
    e.idx = nidx;
    nidx++;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        m = q.pop_front();
        total++;
        if ({pwm_out, period_end, load_ack, cnt} !==
            {m.pwm, m.pe, m.ack, m.c}) begin
          bad++;
          $display("FAIL ph%0d#%0d got pwm=%b pe=%b ack=%b cnt=%0d want pwm=%b pe=%b ack=%b cnt=%0d",
                   m.ph, m.idx, pwm_out, period_end, load_ack, cnt,
                   m.pwm, m.pe, m.ack, m.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int j;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0;
    period = '0; duty = '0; invert = '0;
    @(negedge clk);

    ph = 1;
    tick(4'b0000, 0, 0, 0);
    tick(4'b0000, 0, 0, 0);

    ph = 2;
    rst_n = 1'b1;
    period = 8'd10;
    duty = {8'd12, 8'd10, 8'd3, 8'd0};
    load = 1'b1;
    tick(4'b0000, 0, 0, 0);
    load = 1'b0;
    tick(4'b0000, 0, 1, 0);
    en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      c = k % 10;
      tick({2'b11, c < 3, 1'b0}, c == 9, 0, c);
    end

    ph = 3;
    load = 1'b1;
    period = 8'd6;
    duty = {8'd12, 8'd10, 8'd3, 8'd5};
    for (int k = 5; k <= 9; k++) begin
      tick({2'b11, k < 3, 1'b0}, k == 9, 0, k);
      load = 1'b0;
    end
    for (int k = 0; k < 11; k++) begin
      c = k % 6;
      tick({2'b11, c < 3, c < 5}, c == 5, k == 0, c);
    end

    ph = 4;
    load = 1'b1;
    period = 8'd10;
    duty = {8'd1, 8'd1, 8'd1, 8'd1};
    tick(4'b1100, 1, 0, 5);
    duty = {8'd10, 8'd0, 8'd2, 8'd7};
    tick(4'b1011, 0, 1, 0);
    load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      c = k % 10;
      tick({1'b1, 1'b0, c < 2, c < 7}, c == 9, 0, c);
    end

    ph = 5;
    load = 1'b1;
    period = 8'd8;
    duty = {8'd5, 8'd0, 8'd8, 8'd2};
    mode = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick({1'b1, 1'b0, k < 2, k < 7}, k == 9, 0, k);
      load = 1'b0;
    end
    for (int k = 0; k < 32; k++) begin
      j = k % 16;
      c = (j < 8) ? j : 15 - j;
      tick({c < 5, 1'b0, 1'b1, c < 2}, j == 15, k == 0, c);
    end

    ph = 6;
    en = 1'b0;
    tick(4'b0000, 0, 0, 0);
    load = 1'b1;
    period = 8'd0;
    duty = {8'd5, 8'd5, 8'd5, 8'd5};
    mode = 1'b0;
    invert = 4'b1010;
    tick(4'b0000, 0, 0, 0);
    load = 1'b0;
    tick(4'b1010, 0, 1, 0);
    en = 1'b1;
    repeat (5) tick(4'b1010, 0, 0, 0);

    ph = 7;
    load = 1'b1;
    period = 8'd1;
    tick(4'b1010, 0, 0, 0);
    load = 1'b0;
    tick(4'b0101, 1, 1, 0);
    repeat (4) tick(4'b0101, 1, 0, 0);
    en = 1'b0;
    tick(4'b1010, 0, 0, 0);
    en = 1'b1;
    tick(4'b0101, 1, 0, 0);

    ph = 8;
    load = 1'b1;
    period = 8'd10;
    duty = {8'd12, 8'd10, 8'd3, 8'd0};
    invert = 4'b0000;
    tick(4'b1110, 0, 1, 0);
    load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick({2'b11, k < 3, 1'b0}, 0, 0, k);
    end
    rst_n = 1'b0;
    tick(4'b0000, 0, 0, 0);
    tick(4'b0000, 0, 0, 0);
    rst_n = 1'b1;
    load = 1'b1;
    tick(4'b0000, 0, 0, 0);
    load = 1'b0;
    tick(4'b1110, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      c = k % 10;
      tick({2'b11, c < 3, 1'b0}, c == 9, 0, c);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
